// File: rtl/dsc_seq_pkg.sv
// Shared types and constants for the DSC operation sequencer.
package dsc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Largest value a w-bit run counter can hold.
    function automatic longint unsigned cnt_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/dsc_run_counter.sv
// Run-cycle counter: synchronous clear, count enable, holds at its maximum value.
module dsc_run_counter
    import dsc_seq_pkg::*;
#(
    parameter int WXIP1 = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WXIP1-1:0] countval,
    output logic             overflow
);

    localparam logic [WXIP1-1:0] CNT_MAX = WXIP1'(cnt_max(WXIP1));

    logic [WXIP1-1:0] count_q;
    logic [WXIP1-1:0] count_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != CNT_MAX)) begin
            count_d = count_q + WXIP1'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign countval = count_q;
    assign overflow = (count_q == CNT_MAX);

endmodule

// File: rtl/dsc_op_sequencer.sv
// Sequences one DSC core per operand set: clear, run until finished or budget, return result.
module dsc_op_sequencer
    import dsc_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 2,
    parameter int WXIP1      = 17
) (
    input  logic                             gclk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic                             budget_en,
    input  logic [WXIP1-1:0]                 cycle_budget,
    output logic                             core_rst,
    output logic                             core_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_in,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_out,
    input  logic                             core_op_finished,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_data,
    output logic [WXIP1-1:0]                 out_cycles,
    output logic                             out_truncated
);

    localparam int               DBW     = NUM_INPUTS * DATA_WIDTH;
    localparam logic [WXIP1-1:0] CNT_MAX = WXIP1'(cnt_max(WXIP1));

    seq_state_t       state_q, state_d;
    logic [DBW-1:0]   operand_q, operand_d;
    logic             budget_en_q, budget_en_d;
    logic [WXIP1-1:0] budget_q, budget_d;
    logic             core_en_q, core_en_d;
    logic             out_valid_q, out_valid_d;
    logic [DBW-1:0]   out_data_q, out_data_d;
    logic [WXIP1-1:0] out_cycles_q, out_cycles_d;
    logic             out_trunc_q, out_trunc_d;

    logic             accept;
    logic             in_run;
    logic [WXIP1-1:0] run_cnt;
    logic             run_cnt_sat;
    logic [WXIP1-1:0] run_n;
    logic             budget_hit;
    logic             sat_hit;
    logic             run_done;

    assign in_run = (state_q == RUN);
    assign accept = (state_q == IDLE) && in_valid;

    dsc_run_counter #(
        .WXIP1(WXIP1)
    ) u_run_counter (
        .clk     (gclk),
        .rst     (rst),
        .clr     (accept),
        .en      (in_run),
        .countval(run_cnt),
        .overflow(run_cnt_sat)
    );

    // run_n is the index of the current RUN cycle, starting at 1.
    assign run_n      = run_cnt + WXIP1'(1);
    assign budget_hit = budget_en_q && (budget_q != '0) && (run_n == budget_q);
    assign sat_hit    = (run_n == CNT_MAX) || run_cnt_sat;
    assign run_done   = in_run && (core_op_finished || budget_hit || sat_hit);

    always_ff @(posedge gclk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CLEAR;
            CLEAR:                  state_d = RUN;
            RUN:     if (run_done)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Registered outputs are decoded from the upcoming state so they line up with it.
    always_comb begin
        core_en_d   = (state_d == RUN);
        out_valid_d = (state_d == DONE);
    end

    always_comb begin
        operand_d    = operand_q;
        budget_en_d  = budget_en_q;
        budget_d     = budget_q;
        out_data_d   = out_data_q;
        out_cycles_d = out_cycles_q;
        out_trunc_d  = out_trunc_q;
        if (accept) begin
            operand_d   = in_data;
            budget_en_d = budget_en;
            budget_d    = cycle_budget;
        end
        // A finish in the same cycle as a budget hit counts as a real finish.
        if (run_done) begin
            out_data_d   = core_data_out;
            out_cycles_d = run_n;
            out_trunc_d  = !core_op_finished;
        end
    end

    // NOTE: these are plain registers, not memories, so each gets a defined reset value.
    always_ff @(posedge gclk) begin
        if (rst) begin
            operand_q    <= '0;
            budget_en_q  <= 1'b0;
            budget_q     <= '0;
            core_en_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_cycles_q <= '0;
            out_trunc_q  <= 1'b0;
        end else begin
            operand_q    <= operand_d;
            budget_en_q  <= budget_en_d;
            budget_q     <= budget_d;
            core_en_q    <= core_en_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_cycles_q <= out_cycles_d;
            out_trunc_q  <= out_trunc_d;
        end
    end

    assign in_ready      = !rst && (state_q == IDLE);
    assign core_rst      = rst || (state_q == CLEAR);
    assign core_en       = core_en_q;
    assign core_data_in  = operand_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_cycles    = out_cycles_q;
    assign out_truncated = out_trunc_q;

endmodule
